// File: rtl/led_matrix_scanner.sv
// 8x8 LED matrix scan engine: row multiplexing, inter-row blanking, 8-level PWM.
// Define LED_MATRIX_DOUBLE_BUFFER_EN for front/back buffers with frame-boundary swap.
module led_matrix_scanner #(
    parameter int DIV_LOG2 = 13,
    parameter int BLANK    = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [2:0] wr_row,
    input  logic [7:0] wr_data,
    input  logic       swap_req,
    output logic       swap_done,
    input  logic [2:0] bright,
    output logic [7:0] rows,
    output logic [7:0] cols
);

    localparam logic [DIV_LOG2-1:0] TICK_MAX = {DIV_LOG2{1'b1}};
    localparam logic [DIV_LOG2-1:0] BLANK_T  = DIV_LOG2'(BLANK);

    logic [DIV_LOG2-1:0] tick;
    logic [2:0]          row_idx;
    logic [2:0]          bright_q;
    logic [2:0]          slice;
    logic                lit;
    logic [7:0]          front_row;

    assign slice = tick[DIV_LOG2-1 -: 3];

    always_comb begin
        lit = (tick >= BLANK_T) && (slice <= bright_q);
    end

    // rows and cols are forced dark together so no partial pattern is ever driven
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick     <= '0;
            row_idx  <= '0;
            bright_q <= '0;
            rows     <= '0;
            cols     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            tick <= tick + 1'b1;
            if (tick == TICK_MAX)
                row_idx <= row_idx + 1'b1;
            if (tick == '0)
                bright_q <= bright;
            rows <= lit ? (8'd1 << row_idx) : 8'h00;
            cols <= lit ? front_row : 8'h00;
        end
    end

`ifdef LED_MATRIX_DOUBLE_BUFFER_EN
    logic [7:0] frame_buf [2][8];
    logic       sel;
    logic       pending;
    logic       last_cycle;
    logic       do_swap;

    // sel names the displayed buffer; the other one takes writes
    assign last_cycle = (row_idx == 3'd7) && (tick == TICK_MAX);
    assign do_swap    = last_cycle && (pending || swap_req);
    assign front_row  = frame_buf[sel][row_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the frame buffers are reset so the display starts blank; this keeps them in flops.
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < 8; r++)
                    frame_buf[b][r] <= '0;
            sel       <= 1'b0;
            pending   <= 1'b0;
            swap_done <= 1'b0;
        end else begin
            if (wr_en)
                frame_buf[~sel][wr_row] <= wr_data;
            swap_done <= do_swap;
            if (do_swap) begin
                sel     <= ~sel;
                pending <= 1'b0;
            end else if (swap_req) begin
                pending <= 1'b1;
            end
        end
    end
`else
    logic [7:0] frame_buf [8];

    assign front_row = frame_buf[row_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < 8; r++)
                frame_buf[r] <= '0;
            swap_done <= 1'b0;
        end else begin
            if (wr_en)
                frame_buf[wr_row] <= wr_data;
            swap_done <= swap_req;
        end
    end
`endif

endmodule

// File: doc/led_matrix_scanner.md
# led_matrix_scanner

Time-multiplexed scan engine for the 8x8 LED matrix on the PMOD ja/jb connectors. It holds a frame buffer written row by row by the application and scans one row at a time at a fixed slot rate, with inter-row blanking and 8-level PWM brightness. Its `rows`/`cols` outputs are logical active-high and feed directly into the board-level PMOD pin map, which applies the column inversion and pin ordering.

## Interface
- `DIV_LOG2`, default 13: each row slot is 2**DIV_LOG2 clk cycles. With a 100 MHz clock this gives a 12.2 kHz row rate and a 1.5 kHz frame rate. Must be at least 5.
- `BLANK`, default 64: dark cycles at the start of every row slot. Must satisfy 1 <= BLANK < 2**(DIV_LOG2-3).
- `clk` in 1: system clock; all logic runs on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `wr_en` in 1: write strobe for the frame buffer.
- `wr_row` in 3: row index for the write.
- `wr_data` in 8: pixel data; bit c is column c, 1 means lit.
- `swap_req` in 1: single-cycle pulse that requests a buffer swap at the next frame boundary.
- `swap_done` out 1: single-cycle pulse that marks the first cycle after a swap.
- `bright` in 3: brightness level, 0 is dimmest and 7 is brightest.
- `rows` out 8: one-hot active row, active-high.
- `cols` out 8: lit columns of the active row, active-high.

## Operation
- Counters:
  - `tick` is DIV_LOG2 bits wide and counts every cycle.
  - `row_idx` is 3 bits wide and increments when `tick` wraps from all-ones to 0.
  - `row_idx` wraps from 7 to 0. That wrap is the frame boundary.
- Brightness latch: `bright` is latched into `bright_q` on the cycle where `tick` is 0. Changes made mid-slot take effect at the next slot.
- Slice: `slice` is `tick[DIV_LOG2-1 -: 3]`, which splits each slot into 8 PWM slices.
- On condition: `on = (tick >= BLANK) && (slice <= bright_q)`.
- Outputs when on: `rows` is one-hot at `row_idx` and `cols` is `front[row_idx]`.
- Outputs when not on: `rows` and `cols` are both 0. Both are forced to 0 together so no partial pattern can appear.
- Buffers: there are two 8x8 buffers, `front` (displayed) and `back` (written). A `wr_en` write always goes to `back[wr_row]`.
- Swap request:
  - `swap_req` sets a sticky `pending` flag.
  - Further requests while `pending` is set are merged into the same swap.
- Swap execution:
  - On the last cycle of the frame (`row_idx`=7 and `tick` all-ones), if `pending` is set or `swap_req` is high in that same cycle, the buffer select toggles and `pending` clears.
  - `swap_done` pulses on the following cycle.
- Swap with a simultaneous write: a write in the swap cycle lands in the old back buffer, which becomes the new front. The pixel is therefore visible in the new frame.
- After a swap, the new back buffer holds the stale old front content. The application must rewrite all 8 rows before its next swap.
- Reset mid-operation clears everything immediately. The display goes dark and any pending swap is lost.

## Timing
- Reset values:
  - `rows`, `cols`, `swap_done` = 0.
  - `tick`, `row_idx`, buffer select, `pending`, `bright_q` = 0.
  - Both buffers all-zero.
- `rows`/`cols` are registered. For a tick value t, the output appears at t+1.
- Lit cycles per slot are `(bright_q+1)*2**(DIV_LOG2-3) - BLANK`.
- Write to display latency: the write, then the next swap boundary, then the first cycle of row `wr_row`'s on-window plus 1.
- No backpressure: `wr_en` is accepted every cycle.

## Configuration
- `LED_MATRIX_DOUBLE_BUFFER_EN` defined:
  - Two buffers with swap behaviour as described above.
- `LED_MATRIX_DOUBLE_BUFFER_EN` undefined:
  - A single buffer, which is both written and displayed, so writes are visible from the next scanned cycle of that row.
  - `swap_req` is answered by a `swap_done` pulse exactly one cycle later, with no frame-boundary wait.
  - `pending` is not implemented.

## Test plan
All scenarios use DIV_LOG2=5, BLANK=2: slot is 32 cycles, slice width is 4, frame is 256 cycles.

1. Reset, then idle 300 cycles -> `rows`=`cols`=0 throughout; `swap_done` is never asserted.
2. Write row 3 = 8'hA5, pulse `swap_req`, set `bright`=7 -> `swap_done` on the first cycle of the frame. In row 3's slot, `rows`=8'h08 and `cols`=8'hA5 for exactly 30 cycles per frame (ticks 2..31, each seen one cycle later); all other slots are dark.
3. Same frame as scenario 2 with `bright`=0 -> 2 lit cycles per slot. With `bright`=3 -> 14 lit cycles. A `bright` change mid-slot only takes effect at the next `tick`=0.
4. Pulse `swap_req` three times within one frame -> exactly one swap and one `swap_done`. `wr_en` plus `swap_req` on the last frame cycle -> that row's data shows in the new frame.
5. Assert `reset` during row 5's on-window -> outputs go to 0 immediately, the swap is cancelled, and scanning restarts at row 0 with blank buffers.
6. With the macro undefined: write row 0 = 8'hFF -> visible in the next row 0 slot with no swap. `swap_req` -> `swap_done` exactly 1 cycle later.
